// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Zero-latency lookup from registered state; one resolved-branch update per cycle.
module branch_predictor_btb #(
  parameter int ADDR_W   = 16,
  parameter int ENTRIES  = 16,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_en,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_mispred,
  input  logic              invalidate,
  output logic [15:0]       resolved_count,
  output logic [15:0]       mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 1 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX    = '1;
  localparam logic [CTR_W-1:0] CTR_RST    = CTR_W'(CTR_INIT);
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [CTR_W-1:0]  ctr_d    [ENTRIES];
  logic [15:0]       resolved_q, resolved_d;
  logic [15:0]       mispred_q, mispred_d;

  // Instructions are halfword aligned, so PC bit 0 carries no information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = lookup_pc[0] ^ update_pc[0];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  assign lk_idx = lookup_pc[IDX_W:1];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+1];
  assign up_idx = update_pc[IDX_W:1];
  assign up_tag = update_pc[ADDR_W-1:IDX_W+1];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup reads only registered state: a same-cycle update is seen one cycle later.
  assign pred_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken     = pred_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target    = pred_hit ? target_q[lk_idx] : '0;
  assign resolved_count = resolved_q;
  assign mispred_count  = mispred_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the branches infers a latch.
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (invalidate) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CTR_RST;
      end
    end else if (update_en) begin
      if (up_hit) begin
        if (update_taken) begin
          target_d[up_idx] = update_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
        end
      end else if (update_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target;
        ctr_d[up_idx]    = CTR_WEAK_T;
      end
    end
  end

  // Statistics keep counting even when invalidate discards the table update.
  always_comb begin
    resolved_d = resolved_q;
    mispred_d  = mispred_q;
    if (update_en && (resolved_q != 16'hFFFF)) resolved_d = resolved_q + 16'd1;
    if (update_en && update_mispred && (mispred_q != 16'hFFFF)) mispred_d = mispred_q + 16'd1;
  end

  // NOTE: the table is reset entry-by-entry because reset must leave tags/targets at zero, not just valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      ctr_q      <= ctr_d;
      resolved_q <= resolved_d;
      mispred_q  <= mispred_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: a per-cycle behavioural model
// plus directed vectors with hand-computed expectations.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lookup_pc = 16'h0040;
  logic        pred_hit, pred_taken;
  logic [15:0] pred_target;
  logic        update_en = 1'b0;
  logic [15:0] update_pc = 16'h0;
  logic        update_taken = 1'b0;
  logic [15:0] update_target = 16'h0;
  logic        update_mispred = 1'b0;
  logic        invalidate = 1'b0;
  logic [15:0] resolved_count, mispred_count;

  int n_cmp = 0;
  int n_fail = 0;

  branch_predictor_btb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .update_en      (update_en),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target),
    .update_mispred (update_mispred),
    .invalidate     (invalidate),
    .resolved_count (resolved_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a table indexed by pc[4:1] holding tag pc[15:5],
  // target and a 0..3 counter; predict taken when counter >= 2.
  bit m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];
  int m_res, m_mis;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_res = 0; m_mis = 0;
    end else begin
      int idx, tag;
      idx = (update_pc >> 1) % 16;
      tag = update_pc >> 5;
      if (update_en) begin
        if (m_res < 65535) m_res = m_res + 1;
        if (update_mispred && m_mis < 65535) m_mis = m_mis + 1;
      end
      if (invalidate) begin
        for (int i = 0; i < 16; i++) begin
          m_valid[i] = 0; m_ctr[i] = 1;
        end
      end else if (update_en) begin
        if (m_valid[idx] && m_tag[idx] == tag) begin
          if (update_taken) begin
            m_tgt[idx] = update_target;
            m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          end else begin
            m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
          end
        end else if (update_taken) begin
          m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = update_target; m_ctr[idx] = 2;
        end
      end
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    int idx;
    bit hit;
    idx = (lookup_pc >> 1) % 16;
    hit = m_valid[idx] && (m_tag[idx] == (lookup_pc >> 5));
    check("cyc_hit",    32'(pred_hit),       32'(hit));
    check("cyc_taken",  32'(pred_taken),     32'(hit && m_ctr[idx] >= 2));
    check("cyc_target", 32'(pred_target),    hit ? 32'(m_tgt[idx]) : 32'h0);
    check("cyc_res",    32'(resolved_count), 32'(m_res));
    check("cyc_mis",    32'(mispred_count),  32'(m_mis));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt, input logic mp);
    update_en = 1'b1; update_pc = pc; update_taken = tk; update_target = tgt; update_mispred = mp;
    tick();
    update_en = 1'b0; update_mispred = 1'b0;
  endtask

  task automatic look(input string name, input logic [15:0] pc,
                      input logic hit, input logic tk, input logic [15:0] tgt);
    lookup_pc = pc;
    #1;
    check({name, "_hit"},    32'(pred_hit),    32'(hit));
    check({name, "_taken"},  32'(pred_taken),  32'(tk));
    check({name, "_target"}, 32'(pred_target), 32'(tgt));
  endtask

  initial begin
    logic [15:0] res_before;
    logic        nt_exp [7] = '{0, 0, 0, 0, 1, 1, 1};
    logic        nt_dir [7] = '{0, 0, 0, 1, 1, 1, 1};

    // 1. reset release
    repeat (2) tick();
    rst_n = 1'b1;
    look("t1", 16'h0040, 0, 0, 16'h0000);
    check("t1_res", 32'(resolved_count), 32'h0);
    check("t1_mis", 32'(mispred_count),  32'h0);

    // 2. allocate; bit 0 ignored
    upd(16'h0040, 1, 16'h0100, 0);
    look("t2a", 16'h0040, 1, 1, 16'h0100);
    look("t2b", 16'h0041, 1, 1, 16'h0100);
    check("t2_res", 32'(resolved_count), 32'h1);

    // 3. counter 2 -> 1,0,0 (not taken) -> 1,2,3,3 (taken)
    for (int i = 0; i < 7; i++) begin
      upd(16'h0040, nt_dir[i], 16'h0100, i == 0);
      look($sformatf("t3_%0d", i), 16'h0040, 1, nt_exp[i], 16'h0100);
    end
    check("t3_mis", 32'(mispred_count), 32'h1);

    // 4. alias replaces the entry; not-taken miss changes nothing
    look("t4_alias_miss", 16'h0060, 0, 0, 16'h0000);
    upd(16'h0060, 1, 16'h0200, 1);
    look("t4_alias_hit", 16'h0060, 1, 1, 16'h0200);
    look("t4_old_miss",  16'h0040, 0, 0, 16'h0000);
    upd(16'h0104, 0, 16'h0777, 0);
    look("t4_nt_miss", 16'h0104, 0, 0, 16'h0000);
    look("t4_kept",    16'h0060, 1, 1, 16'h0200);
    check("t4_res", 32'(resolved_count), 32'd10);

    // 5. no bypass, then invalidate beats update
    lookup_pc = 16'h0080;
    update_en = 1'b1; update_pc = 16'h0080; update_taken = 1'b1; update_target = 16'h0300;
    #1;
    check("t5_same_cycle_miss", 32'(pred_hit), 32'h0);
    tick();
    update_en = 1'b0;
    look("t5_next_hit", 16'h0080, 1, 1, 16'h0300);
    res_before = resolved_count;
    invalidate = 1'b1;
    upd(16'h00A0, 1, 16'h0400, 0);
    invalidate = 1'b0;
    look("t5_inv_a0", 16'h00A0, 0, 0, 16'h0000);
    look("t5_inv_80", 16'h0080, 0, 0, 16'h0000);
    look("t5_inv_40", 16'h0040, 0, 0, 16'h0000);
    check("t5_res_inc", 32'(resolved_count), 32'(res_before) + 32'd1);

    // 6. saturation, then async reset mid-cycle
    update_en = 1'b1; update_mispred = 1'b1; update_taken = 1'b0; update_pc = 16'h0104;
    repeat (65537) tick();
    update_en = 1'b0; update_mispred = 1'b0;
    check("t6_res_sat", 32'(resolved_count), 32'hFFFF);
    check("t6_mis_sat", 32'(mispred_count),  32'hFFFF);
    upd(16'h0040, 1, 16'h0500, 0);
    look("t6_pre_reset", 16'h0040, 1, 1, 16'h0500);
    rst_n = 1'b0;
    #1;
    check("t6_rst_hit",    32'(pred_hit),       32'h0);
    check("t6_rst_taken",  32'(pred_taken),     32'h0);
    check("t6_rst_target", 32'(pred_target),    32'h0);
    check("t6_rst_res",    32'(resolved_count), 32'h0);
    check("t6_rst_mis",    32'(mispred_count),  32'h0);
    tick();
    rst_n = 1'b1;
    look("t6_post_miss", 16'h0040, 0, 0, 16'h0000);
    upd(16'h0040, 1, 16'h0600, 0);
    look("t6_first_upd", 16'h0040, 1, 1, 16'h0600);
    check("t6_res_one", 32'(resolved_count), 32'h1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised branch target buffer with per-entry saturating direction counters for the pipelined CPU front end. IF looks up the current PC and gets a taken/not-taken prediction and target in the same cycle, so fetch no longer has to wait for branches to resolve in EX. EX writes back the resolved outcome one entry per cycle. The block also keeps resolved-branch and mispredict statistics.

Parameters:
ADDR_W, 16, PC/target width in bits.
ENTRIES, 16, number of direct-mapped entries; must be a power of 2 and at least 2. IDX_W = clog2(ENTRIES).
CTR_W, 2, direction counter width; counter MSB = predict taken.
CTR_INIT, 1, counter value after reset/invalidate (weakly not-taken at CTR_W=2).

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
lookup_pc  in  ADDR_W  PC of instruction being fetched (IF)
pred_hit  out  1  valid entry with matching tag for lookup_pc
pred_taken  out  1  pred_hit AND counter MSB
pred_target  out  ADDR_W  stored target on hit, 0 on miss
update_en  in  1  EX has a resolved branch this cycle
update_pc  in  ADDR_W  PC of resolved branch
update_taken  in  1  resolved direction
update_target  in  ADDR_W  resolved target (valid when taken)
update_mispred  in  1  EX found the earlier prediction wrong; qualified by update_en
invalidate  in  1  synchronous clear of all valid bits
resolved_count  out  16  number of update_en cycles, saturating
mispred_count  out  16  number of update_en & update_mispred cycles, saturating

Behaviour:
- Address split: bit 0 ignored (halfword-aligned instructions). Index = pc[IDX_W:1]. Tag = pc[ADDR_W-1:IDX_W+1].
- Entry state: valid, tag, target, counter.
- Lookup is combinational from registered state (zero latency). No bypass: a same-cycle update to the looked-up entry becomes visible on the next cycle.
- Update on update_en at the clock edge:
  - Hit (valid and tag match): counter saturating +1 if taken, saturating -1 if not taken, clamped to 0..2^CTR_W-1. Target overwritten only when taken.
  - Miss and taken: allocate, replacing any existing entry at that index. valid=1, tag, target written; counter = 2^(CTR_W-1) (weakly taken).
  - Miss and not taken: no state change.
- invalidate: all valid bits cleared and all counters set to CTR_INIT at the next edge. It takes priority over a same-cycle update, which is discarded. Statistics are not cleared by invalidate.
- Statistics: resolved_count increments on update_en. mispred_count increments on update_en & update_mispred. Both hold at 16'hFFFF. Both still count in a cycle where invalidate discards the update.
- Reset (asynchronous, any time, including mid-update): all valid=0, counters=CTR_INIT, tags/targets=0, both statistics counters=0. Outputs go immediately to pred_hit=0, pred_taken=0, pred_target=0, resolved_count=0, mispred_count=0. The first update is accepted on the first rising edge after rst_n deasserts.
- With update_en=0 and invalidate=0, no state changes.
- X on update_* is tolerated when update_en=0.

Test Plan:
(All with default parameters: index = pc[4:1], tag = pc[15:5].)
1. Reset release, lookup_pc=0x0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000, both statistics counters 0.
2. Update pc=0x0040 taken, target 0x0100 -> next cycle lookup 0x0040 and 0x0041 both give hit=1, taken=1, target=0x0100; resolved_count=1.
3. On the entry from test 2, apply not-taken x3, then taken x4 -> counter sequence 1,0,0 then 1,2,3,3; pred_taken=0 while counter is 0 or 1, and 1 from the second taken update onward.
4. Alias: lookup 0x0060 (same index, different tag) -> miss. Taken update for 0x0060 with target 0x0200 -> 0x0060 hits with target 0x0200; 0x0040 now misses. A not-taken update to an uncached pc leaves the table unchanged.
5. Same-cycle update (pc=0x0080 taken) and lookup 0x0080 -> miss that cycle, hit the next. invalidate together with an update -> every lookup misses next cycle; resolved_count still increments.
6. 65537 cycles of update_en=1 with update_mispred=1 -> both counters hold 0xFFFF. Then rst_n low between clock edges -> all outputs 0 immediately; 0x0040 misses after release.
